// File: rtl/recip_arbiter.sv
// Round-robin arbiter sharing one combinational reciprocal unit among NREQ requesters.
// Optional RECIP_ARB_STATS_EN macro enables the saturating stat_ops/stat_sats counters.
module recip_arbiter #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 24,
    parameter int SETTLE = 1,
    parameter int IDW    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_abs,
    output logic [WIDTH-1:0]      rcp_data,
    output logic                  rcp_abs,
    input  logic [WIDTH-1:0]      rcp_result,
    input  logic                  rcp_sat,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_sat,
    output logic [15:0]           stat_ops,
    output logic [15:0]           stat_sats
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         state, state_nx;
    logic [IDW-1:0] last, grant, id, cand;
    logic [IDW:0]   sum;
    logic           found;
    logic [3:0]     cnt;

    // Search starts just after the last grant, wrapping modulo NREQ.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sum = {1'b0, last} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            cand = sum[IDW-1:0];
            if (!found && req_valid[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = CALC;
            CALC:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcp_data  <= '0;
            rcp_abs   <= 1'b0;
            id        <= '0;
            last      <= IDW'(NREQ-1);
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    rcp_data <= req_data[grant*WIDTH +: WIDTH];
                    rcp_abs  <= req_abs[grant];
                    id       <= grant;
                    last     <= grant;
                    cnt      <= 4'(SETTLE-1);
                end
                CALC: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    // Operand has been stable for SETTLE edges; the result is now valid.
                    rsp_data  <= rcp_result;
                    rsp_sat   <= rcp_sat;
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef RECIP_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops  <= '0;
            stat_sats <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (stat_ops != 16'hFFFF)
                stat_ops <= stat_ops + 16'd1;
            if (rsp_sat && stat_sats != 16'hFFFF)
                stat_sats <= stat_sats + 16'd1;
        end
    end
`else
    assign stat_ops  = '0;
    assign stat_sats = '0;
`endif

endmodule
